opcode_loader: RTL

Upstream feeder for the 96-bit opcode shift register (3 x 32-bit words, newest word at [95:64]).
- Accepts 32-bit command words from the host-interface FIFO over a valid/ready handshake.
- Drives the shift register's shift_enable/serial_in.
- Counts words and, once a full opcode is resident, presents opcode_valid to the decoder and holds off further words until acknowledged.
- Discards stalled partial opcodes via a watchdog timer.

---
 rtl/gpu_pkg.sv | 13 +
 rtl/opcode_watchdog.sv | 44 ++++
 rtl/opcode_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared types and sizing for the opcode front-end.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2
    } loader_state_t;

    localparam int OPCODE_WORDS = 3;
    localparam int CMD_WORD_W   = 32;

endpackage

// File: rtl/opcode_watchdog.sv
// Idle-cycle watchdog: expired fires combinationally in the last allowed idle cycle.
module opcode_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer_d;
    logic [TMR_W-1:0] timer_q;

    assign expired = count_en && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    // Next timer value; wraps to zero on expiry so the loader restarts clean
    always_comb begin
        timer_d = timer_q;
        if (clear) begin
            timer_d = '0;
        end else if (count_en) begin
            if (expired) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end else begin
            timer_d = timer_q;
        end
    end

    // Timer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/opcode_loader.sv
// Feeds 32-bit command words into the opcode shift register and presents
// each complete opcode to the decoder until it is acknowledged.
module opcode_loader
    import gpu_pkg::*;
#(
    parameter int WORD_W         = CMD_WORD_W,
    parameter int WORDS_PER_OP   = OPCODE_WORDS,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic              flush,
    output logic              shift_enable,
    output logic [WORD_W-1:0] serial_in,
    output logic              opcode_valid,
    input  logic              opcode_ack,
    output logic [1:0]        words_loaded,
    output logic              timeout_err
);

    loader_state_t     state_d, state_q;
    logic [1:0]        count_d, count_q;
    logic              shift_d, shift_q;
    logic [WORD_W-1:0] serial_d, serial_q;
    logic              valid_d, valid_q;
    logic              terr_d, terr_q;

    logic accept_s;
    logic wd_clear_s;
    logic wd_count_s;
    logic wd_expired_s;

    assign word_ready = (state_q != PRESENT) && !flush;
    assign accept_s   = word_valid && word_ready;

    // The watchdog only runs while a partial opcode is waiting for its next word
    assign wd_count_s = (state_q == LOAD) && !accept_s && !flush;
    assign wd_clear_s = !wd_count_s;

    opcode_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear_s),
        .count_en(wd_count_s),
        .expired (wd_expired_s)
    );

    // Next-state logic; flush outranks ack and expiry
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shift_d  = accept_s;
        serial_d = accept_s ? word_in : serial_q;
        terr_d   = 1'b0;
        if (flush) begin
            state_d = IDLE;
            count_d = 2'd0;
            shift_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        state_d = LOAD;
                        count_d = 2'd1;
                    end else begin
                        count_d = 2'd0;
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        if (count_q == 2'(WORDS_PER_OP - 1)) begin
                            state_d = PRESENT;
                            count_d = 2'd0;
                        end else begin
                            count_d = count_q + 2'd1;
                        end
                    end else if (wd_expired_s) begin
                        state_d = IDLE;
                        count_d = 2'd0;
                        terr_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
                PRESENT: begin
                    if (opcode_ack) begin
                        state_d = IDLE;
                    end else begin
                        state_d = PRESENT;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = 2'd0;
                end
            endcase
        end
        valid_d = (state_d == PRESENT);
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= 2'd0;
            shift_q  <= 1'b0;
            serial_q <= '0;
            valid_q  <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            valid_q  <= valid_d;
            terr_q   <= terr_d;
        end
    end

    assign shift_enable = shift_q;
    assign serial_in    = serial_q;
    assign opcode_valid = valid_q;
    assign timeout_err  = terr_q;
    assign words_loaded = count_q;

endmodule
